// File: rtl/fft_twiddle_sequencer.sv
// Radix-2 DIT twiddle scheduler: one (cos, -sin) pair per handshake over all stages/butterflies.
// Define FFT_TWIDDLE_INVERSE_EN to add the `inverse` input for conjugate (IFFT) twiddles.
module fft_twiddle_sequencer #(
  parameter int unsigned BIT_WIDTH     = 32,
  parameter int unsigned DECIMAL_POINT = 16,
  parameter int unsigned SIZE_FFT      = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [SIZE_FFT*BIT_WIDTH-1:0]          sine_wave_in,
  input  logic                                   start_val,
  output logic                                   start_rdy,
`ifdef FFT_TWIDDLE_INVERSE_EN
  input  logic                                   inverse,
`endif
  output logic                                   send_val,
  input  logic                                   send_rdy,
  output logic [BIT_WIDTH-1:0]                   tw_real,
  output logic [BIT_WIDTH-1:0]                   tw_imag,
  output logic [$clog2($clog2(SIZE_FFT))-1:0]    stage,
  output logic [$clog2(SIZE_FFT)-2:0]            bfly,
  output logic                                   last,
  output logic                                   done
);

  localparam int unsigned Log = $clog2(SIZE_FFT);
  localparam int unsigned StW = $clog2(Log);
  localparam int unsigned BfW = Log - 1;
  localparam logic [StW-1:0] StMax = StW'(Log - 1);
  localparam logic [BfW-1:0] BfMax = {BfW{1'b1}};

  if (DECIMAL_POINT >= BIT_WIDTH || SIZE_FFT < 4) begin : g_param_check
    $error("fft_twiddle_sequencer: bad DECIMAL_POINT or SIZE_FFT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [StW-1:0]       stage_q, nxt_stage;
  logic [BfW-1:0]       bfly_q, nxt_bfly;
  logic [BIT_WIDTH-1:0] tw_real_q, tw_real_d;
  logic [BIT_WIDTH-1:0] tw_imag_q, tw_imag_d;
  logic [BIT_WIDTH-1:0] sin_k;
  logic                 last_q, last_d;
  logic                 load, clear;
  logic [Log-1:0]       mask, j, k, re_idx;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    clear     = 1'b0;
    nxt_stage = stage_q;
    nxt_bfly  = bfly_q;
    unique case (state_q)
      StIdle: begin
        if (start_val) begin
          state_d   = StRun;
          load      = 1'b1;
          nxt_stage = '0;
          nxt_bfly  = '0;
        end
      end
      StRun: begin
        if (send_rdy) begin
          if (last_q) begin
            state_d = StDone;
            clear   = 1'b1;
          end else if (bfly_q == BfMax) begin
            nxt_bfly  = '0;
            nxt_stage = stage_q + StW'(1);
            load      = 1'b1;
          end else begin
            nxt_bfly = bfly_q + BfW'(1);
            load     = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef FFT_TWIDDLE_INVERSE_EN
  logic inv_q, inv_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inv_q <= 1'b0;
    end else if (state_q == StIdle && start_val) begin
      inv_q <= inverse;
    end
  end

  // The first beat loads in the handshake cycle, before inv_q has captured `inverse`.
  assign inv_sel = (state_q == StIdle) ? inverse : inv_q;
`endif

  // k = (b mod 2^s) << (LOG-1-s); cos comes from the quarter-period offset entry.
  always_comb begin
    mask      = (Log'(1) << nxt_stage) - Log'(1);
    j         = {1'b0, nxt_bfly} & mask;
    k         = j << (StMax - nxt_stage);
    re_idx    = k + Log'(SIZE_FFT / 4);
    sin_k     = sine_wave_in[k*BIT_WIDTH +: BIT_WIDTH];
    tw_real_d = sine_wave_in[re_idx*BIT_WIDTH +: BIT_WIDTH];
`ifdef FFT_TWIDDLE_INVERSE_EN
    tw_imag_d = inv_sel ? sin_k : -sin_k;
`else
    tw_imag_d = -sin_k;
`endif
    last_d    = (nxt_stage == StMax) && (nxt_bfly == BfMax);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      stage_q   <= '0;
      bfly_q    <= '0;
      tw_real_q <= '0;
      tw_imag_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        stage_q   <= nxt_stage;
        bfly_q    <= nxt_bfly;
        tw_real_q <= tw_real_d;
        tw_imag_q <= tw_imag_d;
        last_q    <= last_d;
      end else if (clear) begin
        stage_q   <= '0;
        bfly_q    <= '0;
        tw_real_q <= '0;
        tw_imag_q <= '0;
        last_q    <= 1'b0;
      end
    end
  end

  assign start_rdy = (state_q == StIdle);
  assign send_val  = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign tw_real   = tw_real_q;
  assign tw_imag   = tw_imag_q;
  assign stage     = stage_q;
  assign bfly      = bfly_q;
  assign last      = last_q;

endmodule
